// File: rtl/alu.sv
// 32-bit ALU: combinational result plus a one-cycle registered capture stage
// (result_q, zero_q, out_valid) loaded on in_valid.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [3:0]  alu_op,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic        out_valid
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  // Only the low five bits of op_b form the shift amount.
  assign shamt       = op_b[4:0];
  assign lt_signed   = $signed(op_a) < $signed(op_b);
  assign lt_unsigned = op_a < op_b;

  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_SLL:  result = op_a << shamt;
      OP_SRL:  result = op_a >> shamt;
      OP_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  result = {31'b0, lt_signed};
      OP_SLTU: result = {31'b0, lt_unsigned};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      result_q  <= result;
      zero_q    <= (result == '0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver checks the combinational result against an
// arithmetic reference model and queues expected captures for the monitor.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  alu_op;
  logic        in_valid;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        zero_q;
  logic        out_valid;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_op   (alu_op),
    .in_valid (in_valid),
    .result   (result),
    .result_q (result_q),
    .zero_q   (zero_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_r = '0;
  logic        last_z = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model built from plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint m  = 64'h1_0000_0000;
    longint ua = a;
    longint ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint sh = ub % 32;
    longint p  = 1;
    longint r;
    for (int i = 0; i < sh; i++) p = p * 2;
    case (op)
      4'd0:    r = (ua + ub) % m;
      4'd1:    r = (ua - ub + m) % m;
      4'd2:    r = ua & ub;
      4'd3:    r = ua | ub;
      4'd4:    r = ua ^ ub;
      4'd5:    r = (ua * p) % m;
      4'd6:    r = ua / p;
      4'd7:    r = (sa >= 0) ? sa / p : ((-((-sa + p - 1) / p)) + m) % m;
      4'd8:    r = (sa < sb) ? 1 : 0;
      4'd9:    r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic has_exp, input logic [31:0] exp_r);
    logic [31:0] m;
    exp_t e;
    @(posedge clk);
    #1;
    alu_op = op; op_a = a; op_b = b; in_valid = v;
    #1;
    m = ref_model(op, a, b);
    chk("comb_result", result, m);
    if (has_exp) chk("directed_result", result, exp_r);
    if (v) begin
      e.cyc = cyc + 1;
      e.r   = m;
      e.z   = (m == 32'd0);
      sb_q.push_back(e);
    end
  endtask

  // Pulse reset between edges; any capture queued for the next edge is dropped.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_result_q", result_q, 32'd0);
    chk("rst_zero_q", {31'b0, zero_q}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_comb_result", result, ref_model(alu_op, op_a, op_b));
    in_valid = 1'b0;
    sb_q.delete();
    last_r = '0;
    last_z = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      chk("out_valid_hi", {31'b0, out_valid}, 32'd1);
      chk("result_q", result_q, e.r);
      chk("zero_q", {31'b0, zero_q}, {31'b0, e.z});
      last_r = e.r;
      last_z = e.z;
    end else begin
      chk("out_valid_lo", {31'b0, out_valid}, 32'd0);
      chk("result_q_hold", result_q, last_r);
      chk("zero_q_hold", {31'b0, zero_q}, {31'b0, last_z});
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; alu_op = '0;
    #2;
    chk("init_result_q", result_q, 32'd0);
    chk("init_zero_q", {31'b0, zero_q}, 32'd0);
    chk("init_out_valid", {31'b0, out_valid}, 32'd0);
    #5 rst_n = 1'b1;

    issue(4'b0000, 32'd10, 32'd5, 1'b1, 1'b1, 32'd15);
    issue(4'b0001, 32'd10, 32'd5, 1'b0, 1'b1, 32'd5);
    issue(4'b0001, 32'd0, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(4'b0010, 32'h0F0F_F0F0, 32'h00FF_00FF, 1'b1, 1'b1, 32'h000F_00F0);
    issue(4'b0011, 32'h0F00_F000, 32'h00FF_00FF, 1'b1, 1'b1, 32'h0FFF_F0FF);
    issue(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 1'b1, 32'h5555_5555);
    issue(4'b0101, 32'd1, 32'd5, 1'b1, 1'b1, 32'd32);
    issue(4'b0110, 32'h100, 32'd2, 1'b1, 1'b1, 32'd64);
    issue(4'b0111, 32'h8000_0000, 32'd4, 1'b1, 1'b1, 32'hF800_0000);
    issue(4'b0101, 32'd1, 32'h25, 1'b1, 1'b1, 32'd32);
    issue(4'b0111, 32'h8000_0000, 32'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(4'b0110, 32'h8000_0000, 32'd31, 1'b1, 1'b1, 32'd1);
    issue(4'b0101, 32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'h1234_5678);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd1);
    issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd0);
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, 32'd0);
    issue(4'b0001, 32'd5, 32'd5, 1'b1, 1'b1, 32'd0);
    issue(4'b0000, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3);
    issue(4'b0000, 32'd7, 32'd8, 1'b1, 1'b1, 32'd15);
    reset_pulse();
    issue(4'b0000, 32'd20, 32'd22, 1'b1, 1'b1, 32'd42);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = {b[31:5], 5'd0};
        1: b = {b[31:5], 5'd31};
        2: a = b;
        default: ;
      endcase
      issue(op, a, b, ($urandom_range(0, 3) != 0), 1'b0, 32'd0);
      if (i == 200) reset_pulse();
    end

    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
